// File: rtl/bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : bus_pkg                                                      |
// | Description : Shared definitions for the serial bus master port: state     |
// |               encoding, transfer-direction constants and default widths.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package bus_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 8;

   localparam logic MODE_WRITE = 1'b1;
   localparam logic MODE_READ  = 1'b0;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_REQ        = 3'd1,
      S_ADDR       = 3'd2,
      S_WAIT_ACK   = 3'd3,
      S_WDATA      = 3'd4,
      S_RDATA      = 3'd5,
      S_SPLIT_WAIT = 3'd6,
      S_DONE       = 3'd7
   } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_shifter                                               |
// | Description : Parallel-load register that shifts out MSB first while       |
// |               shifting a serial bit in at the LSB, plus a bit counter.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk      in   clock, rising edge                                         |
// |   rstn     in   asynchronous active-low reset                              |
// |   load_i   in   load pdata_i and clear the bit counter                     |
// |   pdata_i  in   W  parallel load value                                     |
// |   shift_i  in   one bit transferred this cycle                             |
// |   sin_i    in   serial bit entering at the LSB                             |
// |   sout_o   out  current MSB (next bit to send)                             |
// |   pdata_o  out  W  register contents                                       |
// |   last_o   out  counter sits on the final bit position                     |
// +----------------------------------------------------------------------------+
module serial_shifter
   import bus_pkg::*;
#(
   parameter int W = DEF_DATA_W
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load_i,
   input  logic [W-1:0] pdata_i,
   input  logic         shift_i,
   input  logic         sin_i,
   output logic         sout_o,
   output logic [W-1:0] pdata_o,
   output logic         last_o
);

   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  data_q;
   logic [CW-1:0] cnt_q;

   // Shift-out and shift-in are the same left shift: outgoing bits leave at
   // the MSB while incoming bits enter at the LSB, so after W shifts the
   // first received bit ends up as the MSB.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else if (load_i) begin
         data_q <= pdata_i;
         cnt_q  <= '0;
      end else if (shift_i) begin
         data_q <= {data_q[W-2:0], sin_i};
         cnt_q  <= cnt_q + CW'(1);
      end
   end

   assign sout_o  = data_q[W-1];
   assign pdata_o = data_q;
   assign last_o  = (cnt_q == CW'(W - 1));

endmodule
`default_nettype wire

// File: rtl/master_port_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : master_port_ctrl                                             |
// | Description : Serial bus master port. Accepts a user read/write request,   |
// |               arbitrates for the bus, shifts the address out, waits for    |
// |               the slave acknowledge, moves the data serially (with split   |
// |               suspend/resume) and returns a one-cycle completion pulse.    |
// | Config      : MASTER_PORT_TIMEOUT_EN - when defined, an unanswered         |
// |               address ends with rsp_err after ACK_TIMEOUT cycles; when     |
// |               undefined, the port waits for ack indefinitely.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, rstn                    clock / async active-low reset              |
// |   req_valid/req_ready          user request handshake                      |
// |   req_write, req_addr, req_wdata  request contents                         |
// |   rsp_valid, rsp_rdata, rsp_err   completion pulse, read data, error       |
// |   breq / bgrant                bus request / grant                         |
// |   mode                         transfer direction (1 = write)              |
// |   wr_bus, master_valid, slave_ready  outgoing serial bit + handshake       |
// |   rd_bus, slave_valid, master_ready  incoming serial bit + handshake       |
// |   ack, split                   slave acknowledge / split indication        |
// +----------------------------------------------------------------------------+
module master_port_ctrl
   import bus_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              breq,
   input  logic              bgrant,
   output logic              mode,
   output logic              wr_bus,
   output logic              master_valid,
   input  logic              slave_ready,
   input  logic              rd_bus,
   input  logic              slave_valid,
   output logic              master_ready,
   input  logic              ack,
   input  logic              split
);

   state_t state_q, state_d;
   logic   write_q;
   logic   ack_seen_q, ack_seen_d;
   logic   err_q, err_d;

`ifdef MASTER_PORT_TIMEOUT_EN
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   // Counts cycles elapsed since the final address bit transferred.
   logic [TW-1:0] tmo_q, tmo_d;
`endif

   logic              w_accept;
   logic              w_addr_xfer;
   logic              w_wd_xfer;
   logic              w_rd_xfer;
   logic              w_addr_sout;
   logic              w_addr_last;
   logic [ADDR_W-1:0] w_addr_unused;
   logic              w_data_sout;
   logic              w_data_last;
   logic [DATA_W-1:0] w_data_q;
   state_t            w_data_state;

   assign w_accept     = (state_q == S_IDLE) && req_valid;
   assign w_addr_xfer  = (state_q == S_ADDR) && slave_ready;
   assign w_wd_xfer    = (state_q == S_WDATA) && slave_ready;
   assign w_rd_xfer    = (state_q == S_RDATA) && slave_valid;
   assign w_data_state = write_q ? S_WDATA : S_RDATA;

   serial_shifter #(.W(ADDR_W)) u_addr_shifter (
      .clk     (clk),
      .rstn    (rstn),
      .load_i  (w_accept),
      .pdata_i (req_addr),
      .shift_i (w_addr_xfer),
      .sin_i   (1'b0),
      .sout_o  (w_addr_sout),
      .pdata_o (w_addr_unused),
      .last_o  (w_addr_last)
   );

   // Reads load zero so a read never echoes stale write data; writes shift
   // zeros in behind the outgoing bits.
   serial_shifter #(.W(DATA_W)) u_data_shifter (
      .clk     (clk),
      .rstn    (rstn),
      .load_i  (w_accept),
      .pdata_i (req_write ? req_wdata : '0),
      .shift_i (w_wd_xfer || w_rd_xfer),
      .sin_i   ((state_q == S_RDATA) && rd_bus),
      .sout_o  (w_data_sout),
      .pdata_o (w_data_q),
      .last_o  (w_data_last)
   );

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         write_q    <= 1'b0;
         ack_seen_q <= 1'b0;
         err_q      <= 1'b0;
`ifdef MASTER_PORT_TIMEOUT_EN
         tmo_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         ack_seen_q <= ack_seen_d;
         err_q      <= err_d;
`ifdef MASTER_PORT_TIMEOUT_EN
         tmo_q      <= tmo_d;
`endif
         if (w_accept) begin
            write_q <= req_write;
         end
      end
   end

   // Next-state logic. Loss of grant is checked first in every granted
   // state; a final data bit beats a same-cycle split.
   always_comb begin
      state_d    = state_q;
      ack_seen_d = ack_seen_q;
      err_d      = err_q;
`ifdef MASTER_PORT_TIMEOUT_EN
      tmo_d      = tmo_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               state_d    = S_REQ;
               ack_seen_d = 1'b0;
               err_d      = 1'b0;
            end
         end
         S_REQ: begin
            if (bgrant) state_d = S_ADDR;
         end
         S_ADDR: begin
            if (ack) ack_seen_d = 1'b1;
            if (!bgrant) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else if (w_addr_xfer && w_addr_last) begin
               state_d = (ack_seen_q || ack) ? w_data_state : S_WAIT_ACK;
`ifdef MASTER_PORT_TIMEOUT_EN
               tmo_d   = TW'(1);
`endif
            end
         end
         S_WAIT_ACK: begin
            if (ack) ack_seen_d = 1'b1;
            if (!bgrant) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else if (ack) begin
               state_d = w_data_state;
`ifdef MASTER_PORT_TIMEOUT_EN
            end else if (tmo_q >= TW'(ACK_TIMEOUT - 1)) begin
               // DONE lands exactly ACK_TIMEOUT cycles after the last bit.
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               tmo_d   = tmo_q + TW'(1);
`endif
            end
         end
         S_WDATA, S_RDATA: begin
            if (!bgrant) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else if ((w_wd_xfer || w_rd_xfer) && w_data_last) begin
               state_d = S_DONE;
            end else if (split) begin
               state_d = S_SPLIT_WAIT;
            end
         end
         S_SPLIT_WAIT: begin
            if (!split && bgrant) state_d = w_data_state;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decoded from the current state only.
   always_comb begin
      req_ready    = 1'b0;
      breq         = 1'b0;
      mode         = MODE_READ;
      wr_bus       = 1'b0;
      master_valid = 1'b0;
      master_ready = 1'b0;
      rsp_valid    = 1'b0;
      rsp_err      = 1'b0;
      rsp_rdata    = '0;
      case (state_q)
         S_IDLE: req_ready = 1'b1;
         S_REQ:  breq      = 1'b1;
         S_ADDR: begin
            breq         = 1'b1;
            mode         = write_q ? MODE_WRITE : MODE_READ;
            master_valid = 1'b1;
            wr_bus       = w_addr_sout;
         end
         S_WAIT_ACK, S_SPLIT_WAIT: begin
            breq = 1'b1;
            mode = write_q ? MODE_WRITE : MODE_READ;
         end
         S_WDATA: begin
            breq         = 1'b1;
            mode         = write_q ? MODE_WRITE : MODE_READ;
            master_valid = 1'b1;
            wr_bus       = w_data_sout;
         end
         S_RDATA: begin
            breq         = 1'b1;
            mode         = write_q ? MODE_WRITE : MODE_READ;
            master_ready = 1'b1;
         end
         S_DONE: begin
            mode      = write_q ? MODE_WRITE : MODE_READ;
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            rsp_rdata = write_q ? '0 : w_data_q;
         end
         default: req_ready = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_master_port_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_master_port_ctrl                                          |
// | Description : Directed self-checking bench for master_port_ctrl.           |
// | Config      : MASTER_PORT_TIMEOUT_EN selects the ack-timeout scenario.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_master_port_ctrl;

   localparam int ACK_TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req_valid, req_ready, req_write;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata, rsp_rdata;
   logic        rsp_valid, rsp_err, breq, bgrant, mode;
   logic        wr_bus, master_valid, slave_ready;
   logic        rd_bus, slave_valid, master_ready, ack, split;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   master_port_ctrl #(
      .ADDR_W(16), .DATA_W(8), .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .breq(breq), .bgrant(bgrant), .mode(mode),
      .wr_bus(wr_bus), .master_valid(master_valid), .slave_ready(slave_ready),
      .rd_bus(rd_bus), .slave_valid(slave_valid), .master_ready(master_ready),
      .ack(ack), .split(split)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic begin_req(input logic wr, input logic [15:0] a, input logic [7:0] d);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      cyc();
      req_valid = 1'b0;
      chk("breq_in_req", {31'd0, breq}, 32'd1);
   endtask

   task automatic addr_phase(input logic [15:0] a, input int ack_at);
      logic [15:0] bits;
      logic        mv;
      mv = 1'b1;
      for (int i = 0; i < 16; i++) begin
         ack = (i == ack_at);
         bits[15-i] = wr_bus;
         mv &= master_valid & breq;
         cyc();
      end
      ack = 1'b0;
      chk("addr_bits", {16'd0, bits}, {16'd0, a});
      chk("addr_mvalid", {31'd0, mv}, 32'd1);
   endtask

   task automatic wdata_phase(input logic [7:0] d);
      logic [7:0] bits;
      for (int i = 0; i < 8; i++) begin
         bits[7-i] = wr_bus;
         cyc();
      end
      chk("wdata_bits", {24'd0, bits}, {24'd0, d});
   endtask

   task automatic rdata_phase(input logic [7:0] d, input int from, input int to);
      logic mr;
      mr = 1'b1;
      for (int i = from; i <= to; i++) begin
         slave_valid = 1'b1;
         rd_bus = d[7-i];
         mr &= master_ready & ~master_valid & ~mode;
         cyc();
      end
      slave_valid = 1'b0;
      rd_bus = 1'b0;
      chk("rdata_mready", {31'd0, mr}, 32'd1);
   endtask

   task automatic done_chk(input logic [7:0] rd, input logic err);
      chk("done_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("done_rsp_err", {31'd0, rsp_err}, {31'd0, err});
      chk("done_rsp_rdata", {24'd0, rsp_rdata}, {24'd0, rd});
      chk("done_breq", {31'd0, breq}, 32'd0);
   endtask

   initial begin
      logic any;
      logic all;
      int   first;
      logic errv;

      rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      bgrant = 1'b0; slave_ready = 1'b1; rd_bus = 1'b0; slave_valid = 1'b0;
      ack = 1'b0; split = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ctrl", {24'd0, breq, master_valid, master_ready, mode, wr_bus,
                         rsp_valid, rsp_err, req_ready}, 32'h01);
      chk("reset_rdata", {24'd0, rsp_rdata}, 32'd0);
      rstn = 1'b1;
      cyc();

      // Write 0x1234 / 0xA5, grant after two cycles, ack at address bit 3
      begin_req(1'b1, 16'h1234, 8'hA5);
      chk("req_mode_zero", {31'd0, mode}, 32'd0);
      cyc();
      chk("req_wait_breq", {31'd0, breq}, 32'd1);
      bgrant = 1'b1;
      cyc();
      chk("addr_mode_wr", {31'd0, mode}, 32'd1);
      addr_phase(16'h1234, 3);
      wdata_phase(8'hA5);
      done_chk(8'h00, 1'b0);
      chk("done_mode_wr", {31'd0, mode}, 32'd1);
      cyc();
      chk("idle_after_wr", {29'd0, rsp_valid, req_ready, mode}, 32'b010);

      // Read 0x0002, data 0xC3, then back-to-back request
      begin_req(1'b0, 16'h0002, 8'h00);
      cyc();
      chk("rd_addr_mode", {31'd0, mode}, 32'd0);
      addr_phase(16'h0002, 0);
      rdata_phase(8'hC3, 0, 7);
      done_chk(8'hC3, 1'b0);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0040;
      chk("b2b_done_not_ready", {31'd0, req_ready}, 32'd0);
      cyc();
      chk("b2b_idle_gap", {30'd0, req_ready, breq}, 32'b10);
      cyc();
      req_valid = 1'b0;
      chk("b2b_accepted", {31'd0, breq}, 32'd1);

      // Split after three read bits, grant withdrawn for 20 cycles
      cyc();
      addr_phase(16'h0040, 2);
      rdata_phase(8'hB2, 0, 2);
      split = 1'b1;
      cyc();
      split = 1'b0; bgrant = 1'b0;
      all = 1'b1;
      for (int i = 0; i < 20; i++) begin
         all &= breq & ~master_ready & ~master_valid & ~rsp_valid;
         cyc();
      end
      chk("split_hold", {31'd0, all}, 32'd1);
      bgrant = 1'b1;
      cyc();
      rdata_phase(8'hB2, 3, 7);
      done_chk(8'hB2, 1'b0);
      cyc();

      // Address never acknowledged
      begin_req(1'b1, 16'h00FF, 8'h11);
      cyc();
      addr_phase(16'h00FF, -1);
`ifdef MASTER_PORT_TIMEOUT_EN
      first = 0; errv = 1'b0;
      for (int k = 1; k <= ACK_TIMEOUT + 4; k++) begin
         if (rsp_valid && first == 0) begin
            first = k; errv = rsp_err;
         end
         cyc();
      end
      chk("tmo_latency", first, ACK_TIMEOUT);
      chk("tmo_err", {31'd0, errv}, 32'd1);
`else
      any = 1'b0; all = 1'b1;
      for (int k = 0; k < 40; k++) begin
         any |= rsp_valid;
         all &= breq;
         cyc();
      end
      chk("noack_no_rsp", {31'd0, any}, 32'd0);
      chk("noack_breq", {31'd0, all}, 32'd1);
      ack = 1'b1;
      cyc();
      ack = 1'b0;
      wdata_phase(8'h11);
      done_chk(8'h00, 1'b0);
      cyc();
`endif

      // Grant lost during address
      begin_req(1'b1, 16'h5555, 8'h0F);
      cyc();
      repeat (5) cyc();
      bgrant = 1'b0;
      cyc();
      done_chk(8'h00, 1'b1);
      bgrant = 1'b1;
      cyc();

      // Split coincides with final read bit
      begin_req(1'b0, 16'h0100, 8'h00);
      cyc();
      addr_phase(16'h0100, 15);
      rdata_phase(8'h5A, 0, 6);
      split = 1'b1; slave_valid = 1'b1; rd_bus = 1'b0;
      cyc();
      split = 1'b0; slave_valid = 1'b0;
      done_chk(8'h5A, 1'b0);
      cyc();

      // Reset during write data bit 4
      begin_req(1'b1, 16'h0F0F, 8'h96);
      cyc();
      addr_phase(16'h0F0F, 0);
      repeat (4) cyc();
      chk("wd4_mvalid", {31'd0, master_valid}, 32'd1);
      rstn = 1'b0;
      #1;
      chk("rst_async", {28'd0, breq, master_valid, mode, wr_bus}, 32'd0);
      any = 1'b0;
      for (int i = 0; i < 3; i++) begin
         any |= rsp_valid;
         cyc();
      end
      rstn = 1'b1;
      cyc();
      any |= rsp_valid;
      chk("rst_no_rsp", {31'd0, any}, 32'd0);
      begin_req(1'b1, 16'hABCD, 8'h3C);
      cyc();
      addr_phase(16'hABCD, 5);
      wdata_phase(8'h3C);
      done_chk(8'h00, 1'b0);
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
